// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Payload request / serial line bundle between the parity calculator side and the TX controller.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  par_bit;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output par_bit,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  par_bit,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register with bit counter; next_bit lets the controller register TX_OUT one cycle ahead.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  cur_bit,
    output logic                  next_bit,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= data;
            cnt_q   <= '0;
        end else if (shift_en && !ser_done) begin
            // Saturates at the last bit so the counter can never wrap inside a frame.
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign cur_bit  = shift_q[0];
    assign next_bit = shift_q[1];
    assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop; one bit per clk.
//  state  | meaning
//  IDLE   | line high, waiting for Data_Valid
//  START  | start bit on the line, par_bit captured at its closing edge
//  DATA   | payload bits LSB-first, DATA_WIDTH cycles
//  PARITY | captured parity bit on the line
//  STOP   | stop bit; Data_Valid here chains straight into the next frame
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);

    tx_state_t state_q, state_d;

    logic load;
    logic shift_en;
    logic par_cap;
    logic latch_en;
    logic tx_d, tx_q;
    logic busy_d, busy_q;
    logic par_q;
    logic par_en_q;
    logic cur_bit;
    logic next_bit;
    logic ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data     (bus.P_DATA),
        .cur_bit  (cur_bit),
        .next_bit (next_bit),
        .ser_done (ser_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tx_q     <= IDLE_LVL;
            busy_q   <= 1'b0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (par_cap) begin
                par_q <= bus.par_bit;
            end
            if (latch_en) begin
                par_en_q <= bus.PAR_EN;
            end
        end
    end

    // Outputs are registered from the next state, so every branch states the line level for next cycle.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        par_cap  = 1'b0;
        latch_en = 1'b0;
        tx_d     = IDLE_LVL;
        busy_d   = 1'b1;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.Data_Valid) begin
                    state_d  = START;
                    load     = 1'b1;
                    latch_en = 1'b1;
                    tx_d     = START_BIT;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                par_cap = 1'b1;
                tx_d    = cur_bit;
            end
            DATA: begin
                if (ser_done) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    shift_en = 1'b1;
                    tx_d     = next_bit;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
            end
            STOP: begin
                if (bus.Data_Valid) begin
                    state_d  = START;
                    load     = 1'b1;
                    latch_en = 1'b1;
                    tx_d     = START_BIT;
                end else begin
                    state_d = IDLE;
                    tx_d    = IDLE_LVL;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule
